// File: rtl/disp_colr_adapt_pkg.sv
// Shared definitions for the display colour adapter: mode encodings,
// the ordered-dither matrix and the colour bar count.
package disp_colr_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_DITHER = 2'd1,
        MODE_BARS   = 2'd2,
        MODE_BLANK  = 2'd3
    } mode_t;

    localparam int BAR_COUNT = 8;
    localparam int BAR_IDX_W = $clog2(BAR_COUNT);

    // 4x4 Bayer matrix, entry [row][col] at bits row*16 + col*4.
    // Rows: {0,8,2,10}, {12,4,14,6}, {3,11,1,9}, {15,7,13,5}.
    localparam logic [63:0] BAYER_TABLE = {
        4'd5,  4'd13, 4'd7,  4'd15,
        4'd9,  4'd1,  4'd11, 4'd3,
        4'd6,  4'd14, 4'd4,  4'd12,
        4'd10, 4'd2,  4'd8,  4'd0
    };

    function automatic logic [3:0] bayer_at(input logic [1:0] row, input logic [1:0] col);
        return BAYER_TABLE[{row, col, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/disp_colr_adapt_if.sv
// Video bundle seen by a display colour adapter: source side timing and
// colour going in, delayed timing and converted colour coming out.
interface disp_colr_adapt_if #(
    parameter int CHANNELS = 3,
    parameter int BPC_IN   = 5,
    parameter int BPC_OUT  = 8
);
    logic [1:0]                  mode;
    logic                        in_hsync;
    logic                        in_vsync;
    logic                        in_de;
    logic [CHANNELS*BPC_IN-1:0]  in_colr;
    logic                        out_hsync;
    logic                        out_vsync;
    logic                        out_de;
    logic [CHANNELS*BPC_OUT-1:0] out_colr;

    modport master (
        output mode, in_hsync, in_vsync, in_de, in_colr,
        input  out_hsync, out_vsync, out_de, out_colr
    );

    modport slave (
        input  mode, in_hsync, in_vsync, in_de, in_colr,
        output out_hsync, out_vsync, out_de, out_colr
    );
endinterface

// File: rtl/disp_colr_adapt_widen.sv
// One colour channel, second pipeline stage: width conversion (replicate,
// truncate or dither add with saturation), bars/blank selection, de gating.
module colr_widen
    import disp_colr_pkg::*;
#(
    parameter int BPC_IN  = 5,
    parameter int BPC_OUT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  mode_t              mode,
    input  logic               de,
    input  logic               bar_on,
    input  logic [BPC_IN-1:0]  colr,
    input  logic [BPC_IN-1:0]  offset,
    output logic [BPC_OUT-1:0] colr_out
);

    logic [BPC_OUT-1:0] pass_val;
    logic [BPC_OUT-1:0] dith_val;
    logic [BPC_OUT-1:0] colr_d;
    logic [BPC_OUT-1:0] colr_q;

    generate
        if (BPC_OUT >= BPC_IN) begin : g_expand
            logic unused_offset;

            // Repeat the input MSB-first until the output word is filled.
            always_comb begin
                pass_val = '0;
                for (int i = 0; i < BPC_OUT; i++) begin
                    pass_val[BPC_OUT-1-i] = colr[BPC_IN-1-(i % BPC_IN)];
                end
            end

            assign dith_val      = pass_val;
            assign unused_offset = ^offset;
        end else begin : g_narrow
            logic [BPC_IN:0] sum;
            logic            unused_lo;

            // Add the dither offset, clamp at full scale, keep the top bits.
            always_comb begin
                sum      = {1'b0, colr} + {1'b0, offset};
                dith_val = sum[BPC_IN] ? '1 : sum[BPC_IN-1 -: BPC_OUT];
            end

            assign pass_val  = colr[BPC_IN-1 -: BPC_OUT];
            assign unused_lo = ^sum[BPC_IN-BPC_OUT-1:0];
        end
    endgenerate

    // Mode select; colour is black whenever the pixel is outside the active area.
    always_comb begin
        colr_d = '0;
        if (de) begin
            case (mode)
                MODE_PASS:   colr_d = pass_val;
                MODE_DITHER: colr_d = dith_val;
                MODE_BARS:   colr_d = {BPC_OUT{bar_on}};
                MODE_BLANK:  colr_d = '0;
                default:     colr_d = '0;
            endcase
        end
    end

    // Output colour register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colr_q <= '0;
        end else begin
            colr_q <= colr_d;
        end
    end

    assign colr_out = colr_q;

endmodule

// File: rtl/disp_colr_adapt.sv
// Pixel-clock colour adapter: x/y and bar counters, frame-synchronous mode
// register, stage-1 input/offset capture and the sync delay line. The
// per-channel conversion lives in colr_widen.
module disp_colr_adapt
    import disp_colr_pkg::*;
#(
    parameter int BPC_IN    = 5,
    parameter int BPC_OUT   = 8,
    parameter int CHANNELS  = 3,
    parameter int CORDW     = 16,
    parameter int BAR_W     = 64,
    parameter bit HS_ACTIVE = 1'b1,
    parameter bit VS_ACTIVE = 1'b1
) (
    input  logic                        clk_pix,
    input  logic                        rst_pix_n,
    input  logic [1:0]                  mode,
    input  logic                        in_hsync,
    input  logic                        in_vsync,
    input  logic                        in_de,
    input  logic [CHANNELS*BPC_IN-1:0]  in_colr,
    output logic                        out_hsync,
    output logic                        out_vsync,
    output logic                        out_de,
    output logic [CHANNELS*BPC_OUT-1:0] out_colr
);

    localparam int D   = (BPC_IN > BPC_OUT) ? (BPC_IN - BPC_OUT) : 0;
    localparam int SHR = (D <= 4) ? (4 - D) : 0;
    localparam int SHL = (D > 4) ? (D - 4) : 0;

    logic [CORDW-1:0]            x_q, x_d, y_q, y_d;
    logic [CORDW-1:0]            bar_pix_q, bar_pix_d;
    logic [BAR_IDX_W-1:0]        bar_idx_q, bar_idx_d;
    logic                        de_prev_q, de_prev_d;
    logic                        vs_prev_q, vs_prev_d;
    mode_t                       mode_q, mode_d;
    logic                        s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_de_q, s1_de_d;
    logic [CHANNELS*BPC_IN-1:0]  s1_colr_q, s1_colr_d;
    logic [BPC_IN-1:0]           s1_off_q, s1_off_d;
    logic [BAR_IDX_W-1:0]        s1_bar_q, s1_bar_d;
    logic                        out_hs_q, out_hs_d, out_vs_q, out_vs_d, out_de_q, out_de_d;
    logic                        vs_edge, de_fall;
    logic [3:0]                  bayer_t;
    logic [15:0]                 off_full;
    logic                        unused_offset_bits;

    // Counters, mode capture and the stage-1/stage-2 next values. mode_q is
    // both the active mode and the stage-1 mode: it loads on the same edge
    // that captures the pixel sampled at the vsync edge.
    always_comb begin
        vs_edge   = (in_vsync == VS_ACTIVE) && (vs_prev_q != VS_ACTIVE);
        de_fall   = de_prev_q && !in_de;

        x_d       = x_q;
        y_d       = y_q;
        bar_pix_d = bar_pix_q;
        bar_idx_d = bar_idx_q;
        de_prev_d = in_de;
        vs_prev_d = in_vsync;
        mode_d    = vs_edge ? mode_t'(mode) : mode_q;

        if (in_de) begin
            x_d = x_q + CORDW'(1);
            if (bar_pix_q == CORDW'(BAR_W - 1)) begin
                bar_pix_d = '0;
                bar_idx_d = bar_idx_q + BAR_IDX_W'(1);
            end else begin
                bar_pix_d = bar_pix_q + CORDW'(1);
            end
        end else if (de_fall) begin
            x_d       = '0;
            bar_pix_d = '0;
            bar_idx_d = '0;
            y_d       = y_q + CORDW'(1);
        end
        if (vs_edge) begin
            y_d = '0;
        end

        bayer_t            = bayer_at(y_q[1:0], x_q[1:0]);
        off_full           = ({12'b0, bayer_t} >> SHR) << SHL;
        unused_offset_bits = ^off_full;

        s1_hs_d   = in_hsync;
        s1_vs_d   = in_vsync;
        s1_de_d   = in_de;
        s1_colr_d = in_colr;
        s1_off_d  = off_full[BPC_IN-1:0];
        s1_bar_d  = bar_idx_q;

        out_hs_d  = s1_hs_q;
        out_vs_d  = s1_vs_q;
        out_de_d  = s1_de_q;
    end

    // State, stage-1 and sync delay registers.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            x_q       <= '0;
            y_q       <= '0;
            bar_pix_q <= '0;
            bar_idx_q <= '0;
            de_prev_q <= 1'b0;
            vs_prev_q <= ~VS_ACTIVE;
            mode_q    <= MODE_PASS;
            s1_hs_q   <= ~HS_ACTIVE;
            s1_vs_q   <= ~VS_ACTIVE;
            s1_de_q   <= 1'b0;
            s1_colr_q <= '0;
            s1_off_q  <= '0;
            s1_bar_q  <= '0;
            out_hs_q  <= ~HS_ACTIVE;
            out_vs_q  <= ~VS_ACTIVE;
            out_de_q  <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            bar_pix_q <= bar_pix_d;
            bar_idx_q <= bar_idx_d;
            de_prev_q <= de_prev_d;
            vs_prev_q <= vs_prev_d;
            mode_q    <= mode_d;
            s1_hs_q   <= s1_hs_d;
            s1_vs_q   <= s1_vs_d;
            s1_de_q   <= s1_de_d;
            s1_colr_q <= s1_colr_d;
            s1_off_q  <= s1_off_d;
            s1_bar_q  <= s1_bar_d;
            out_hs_q  <= out_hs_d;
            out_vs_q  <= out_vs_d;
            out_de_q  <= out_de_d;
        end
    end

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
            colr_widen #(
                .BPC_IN  (BPC_IN),
                .BPC_OUT (BPC_OUT)
            ) u_widen (
                .clk      (clk_pix),
                .rst_n    (rst_pix_n),
                .mode     (mode_q),
                .de       (s1_de_q),
                .bar_on   (s1_bar_q[k % 3]),
                .colr     (s1_colr_q[k*BPC_IN +: BPC_IN]),
                .offset   (s1_off_q),
                .colr_out (out_colr[k*BPC_OUT +: BPC_OUT])
            );
        end
    endgenerate

    assign out_hsync = out_hs_q;
    assign out_vsync = out_vs_q;
    assign out_de    = out_de_q;

endmodule

// File: tb/tb_disp_colr_adapt.sv
// Directed bench for disp_colr_adapt: a 5->8 instance and an 8->5 instance
// share clock, reset, mode and timing; colour is fed per instance. Each
// vector carries hand-computed expected outputs that appear two cycles later.
module tb_disp_colr_adapt;
    import disp_colr_pkg::*;

    typedef struct packed {
        logic [1:0]  mode;
        logic        hs;
        logic        vs;
        logic        de;
        logic [14:0] ca;
        logic [23:0] cb;
        logic [23:0] ea;
        logic [14:0] eb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    vec_t prev;
    vec_t rst_rec;
    vec_t vecs[$];
    logic [3:0] dmask [4];

    disp_colr_adapt_if #(.CHANNELS(3), .BPC_IN(5), .BPC_OUT(8)) ifa ();
    disp_colr_adapt_if #(.CHANNELS(3), .BPC_IN(8), .BPC_OUT(5)) ifb ();

    always #5 clk = ~clk;

    disp_colr_adapt #(
        .BPC_IN(5), .BPC_OUT(8), .CHANNELS(3), .CORDW(16), .BAR_W(4),
        .HS_ACTIVE(1'b1), .VS_ACTIVE(1'b1)
    ) dut_a (
        .clk_pix(clk), .rst_pix_n(rst_n), .mode(ifa.mode),
        .in_hsync(ifa.in_hsync), .in_vsync(ifa.in_vsync), .in_de(ifa.in_de),
        .in_colr(ifa.in_colr), .out_hsync(ifa.out_hsync), .out_vsync(ifa.out_vsync),
        .out_de(ifa.out_de), .out_colr(ifa.out_colr)
    );

    disp_colr_adapt #(
        .BPC_IN(8), .BPC_OUT(5), .CHANNELS(3), .CORDW(16), .BAR_W(4),
        .HS_ACTIVE(1'b1), .VS_ACTIVE(1'b1)
    ) dut_b (
        .clk_pix(clk), .rst_pix_n(rst_n), .mode(ifb.mode),
        .in_hsync(ifb.in_hsync), .in_vsync(ifb.in_vsync), .in_de(ifb.in_de),
        .in_colr(ifb.in_colr), .out_hsync(ifb.out_hsync), .out_vsync(ifb.out_vsync),
        .out_de(ifb.out_de), .out_colr(ifb.out_colr)
    );

    function automatic vec_t mk(logic [1:0] m, logic hs, logic vs, logic de,
                                logic [14:0] ca, logic [23:0] cb,
                                logic [23:0] ea, logic [14:0] eb);
        vec_t v;
        v.mode = m; v.hs = hs; v.vs = vs; v.de = de;
        v.ca = ca; v.cb = cb; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    function automatic vec_t idle(logic [1:0] m, logic hs, logic vs);
        return mk(m, hs, vs, 1'b0, 15'h1234, 24'hA5A5A5, 24'h0, 15'h0);
    endfunction

    task automatic check_val(string name, int idx, logic [23:0] act, logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_output(vec_t e, int idx);
        check_val("de_a",    idx, 24'(ifa.out_de),    24'(e.de));
        check_val("hsync_a", idx, 24'(ifa.out_hsync), 24'(e.hs));
        check_val("vsync_a", idx, 24'(ifa.out_vsync), 24'(e.vs));
        check_val("colr_a",  idx, ifa.out_colr,       e.ea);
        check_val("de_b",    idx, 24'(ifb.out_de),    24'(e.de));
        check_val("hsync_b", idx, 24'(ifb.out_hsync), 24'(e.hs));
        check_val("vsync_b", idx, 24'(ifb.out_vsync), 24'(e.vs));
        check_val("colr_b",  idx, 24'(ifb.out_colr),  24'(e.eb));
    endtask

    task automatic drive(vec_t v);
        ifa.mode = v.mode; ifa.in_hsync = v.hs; ifa.in_vsync = v.vs;
        ifa.in_de = v.de;  ifa.in_colr = v.ca;
        ifb.mode = v.mode; ifb.in_hsync = v.hs; ifb.in_vsync = v.vs;
        ifb.in_de = v.de;  ifb.in_colr = v.cb;
    endtask

    // Drive one pixel, advance one clock, and check the pixel driven one
    // step earlier (two cycles of latency relative to its input cycle).
    task automatic apply_stimulus(vec_t v, int idx);
        drive(v);
        @(posedge clk);
        #1;
        check_output(prev, idx);
        prev = v;
    endtask

    localparam logic [14:0] CA1 = {5'b00001, 5'b11111, 5'b10110};
    localparam logic [23:0] EA1 = {8'h08, 8'hFF, 8'hB5};
    localparam logic [14:0] CA2 = {5'b10000, 5'b00000, 5'b01001};
    localparam logic [23:0] EA2 = {8'h84, 8'h00, 8'h4A};
    localparam logic [14:0] CA3 = {3{5'b10110}};
    localparam logic [23:0] EA3 = {3{8'hB5}};
    localparam logic [23:0] CB1 = {8'hF0, 8'h0C, 8'h87};
    localparam logic [14:0] EB1 = {5'h1E, 5'h01, 5'h10};
    localparam logic [23:0] CB2 = {3{8'h0C}};
    localparam logic [14:0] EB_ONE = {3{5'd1}};
    localparam logic [14:0] EB_TWO = {3{5'd2}};

    initial begin
        logic [2:0]  bidx;
        logic [23:0] ea_bar;
        logic [14:0] eb_bar;

        rst_rec = mk(MODE_PASS, 1'b0, 1'b0, 1'b0, 15'h0, 24'h0, 24'h0, 15'h0);
        dmask[0] = 4'b1010; dmask[1] = 4'b0101; dmask[2] = 4'b1010; dmask[3] = 4'b0101;

        // Reset held with toggling inputs: outputs stay at reset values.
        rst_n = 1'b0;
        drive(idle(MODE_BLANK, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            drive(mk(2'(i), i[0], ~i[0], 1'b1, CA1, CB1, 24'h0, 15'h0));
            @(posedge clk);
            #1;
            check_output(rst_rec, 1000 + i);
        end
        drive(idle(MODE_BLANK, 1'b0, 1'b0));
        #2 rst_n = 1'b1;
        prev = rst_rec;

        // PASS right after reset (BLANK requested but no vsync edge yet).
        vecs.push_back(idle(MODE_BLANK, 1'b0, 1'b0));
        vecs.push_back(idle(MODE_BLANK, 1'b0, 1'b0));
        vecs.push_back(mk(MODE_BLANK, 1'b0, 1'b0, 1'b1, CA3, CB1, EA3, EB1));
        vecs.push_back(mk(MODE_BLANK, 1'b0, 1'b0, 1'b1, CA1, CB2, EA1, EB_ONE));
        vecs.push_back(mk(MODE_BLANK, 1'b0, 1'b0, 1'b1, CA2, CB1, EA2, EB1));
        vecs.push_back(mk(MODE_BLANK, 1'b0, 1'b0, 1'b1, CA3, CB2, EA3, EB_ONE));
        vecs.push_back(idle(MODE_BLANK, 1'b1, 1'b0));
        vecs.push_back(idle(MODE_BLANK, 1'b1, 1'b0));
        vecs.push_back(idle(MODE_BLANK, 1'b0, 1'b0));

        // DITHER over a 4x4 block of 0x0C, then a saturating line of 0xFF.
        vecs.push_back(idle(MODE_DITHER, 1'b0, 1'b1));
        vecs.push_back(idle(MODE_DITHER, 1'b0, 1'b0));
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                vecs.push_back(mk(MODE_DITHER, 1'b0, 1'b0, 1'b1, CA3, CB2, EA3,
                                  dmask[y][x] ? EB_TWO : EB_ONE));
            end
            vecs.push_back(idle(MODE_DITHER, 1'b1, 1'b0));
            vecs.push_back(idle(MODE_DITHER, 1'b0, 1'b0));
        end
        for (int x = 0; x < 4; x++) begin
            vecs.push_back(mk(MODE_DITHER, 1'b0, 1'b0, 1'b1, CA1, 24'hFFFFFF, EA1, 15'h7FFF));
        end
        vecs.push_back(idle(MODE_DITHER, 1'b1, 1'b0));
        vecs.push_back(idle(MODE_DITHER, 1'b0, 1'b0));

        // BARS: 33-pixel line covering all eight bars and the wrap, then a short line.
        vecs.push_back(idle(MODE_BARS, 1'b0, 1'b1));
        vecs.push_back(idle(MODE_BARS, 1'b0, 1'b0));
        for (int x = 0; x < 33; x++) begin
            bidx   = 3'((x / 4) % 8);
            ea_bar = {bidx[2] ? 8'hFF : 8'h00, bidx[1] ? 8'hFF : 8'h00, bidx[0] ? 8'hFF : 8'h00};
            eb_bar = {bidx[2] ? 5'h1F : 5'h00, bidx[1] ? 5'h1F : 5'h00, bidx[0] ? 5'h1F : 5'h00};
            vecs.push_back(mk(MODE_BARS, 1'b0, 1'b0, 1'b1, CA1, CB1, ea_bar, eb_bar));
        end
        vecs.push_back(idle(MODE_BARS, 1'b1, 1'b0));
        vecs.push_back(idle(MODE_BARS, 1'b0, 1'b0));
        for (int x = 0; x < 5; x++) begin
            vecs.push_back(mk(MODE_BARS, 1'b0, 1'b0, 1'b1, CA2, CB2,
                              (x == 4) ? 24'h0000FF : 24'h0, (x == 4) ? 15'h001F : 15'h0));
        end
        vecs.push_back(idle(MODE_BARS, 1'b0, 1'b0));

        // PASS with BLANK requested mid-frame: PASS holds until the next vsync edge.
        vecs.push_back(idle(MODE_PASS, 1'b0, 1'b1));
        vecs.push_back(idle(MODE_PASS, 1'b0, 1'b0));
        vecs.push_back(mk(MODE_PASS,  1'b0, 1'b0, 1'b1, CA1, CB1, EA1, EB1));
        vecs.push_back(mk(MODE_PASS,  1'b0, 1'b0, 1'b1, CA2, CB2, EA2, EB_ONE));
        vecs.push_back(mk(MODE_BLANK, 1'b0, 1'b0, 1'b1, CA1, CB1, EA1, EB1));
        vecs.push_back(mk(MODE_BLANK, 1'b0, 1'b0, 1'b1, CA3, CB2, EA3, EB_ONE));
        vecs.push_back(idle(MODE_BLANK, 1'b1, 1'b0));
        vecs.push_back(idle(MODE_BLANK, 1'b0, 1'b0));
        vecs.push_back(mk(MODE_BLANK, 1'b0, 1'b0, 1'b1, CA2, CB1, EA2, EB1));
        vecs.push_back(mk(MODE_BLANK, 1'b0, 1'b0, 1'b1, CA1, CB2, EA1, EB_ONE));
        vecs.push_back(idle(MODE_BLANK, 1'b0, 1'b0));
        vecs.push_back(idle(MODE_BLANK, 1'b0, 1'b1));
        vecs.push_back(idle(MODE_BLANK, 1'b0, 1'b0));
        for (int x = 0; x < 3; x++) begin
            vecs.push_back(mk(MODE_BLANK, 1'b0, 1'b0, 1'b1, CA1, CB1, 24'h0, 15'h0));
        end
        vecs.push_back(idle(MODE_BLANK, 1'b1, 1'b0));
        vecs.push_back(idle(MODE_BLANK, 1'b0, 1'b0));
        // Start of a line that the mid-line reset interrupts.
        for (int x = 0; x < 3; x++) begin
            vecs.push_back(mk(MODE_BLANK, 1'b1, 1'b0, 1'b1, CA2, CB2, 24'h0, 15'h0));
        end

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i], i);
        end

        // Asynchronous reset between clock edges while de is high.
        #2 rst_n = 1'b0;
        #1;
        check_output(rst_rec, 2000);
        @(posedge clk);
        #1;
        check_output(rst_rec, 2001);
        #2 rst_n = 1'b1;
        prev = rst_rec;

        // After release x/y restart at 0: the first pixel uses B[0][0].
        apply_stimulus(mk(MODE_DITHER, 1'b0, 1'b1, 1'b1, CA3, CB2, EA3, EB_ONE), 3000);
        apply_stimulus(mk(MODE_DITHER, 1'b0, 1'b1, 1'b1, CA1, CB2, EA1, EB_TWO), 3001);
        apply_stimulus(mk(MODE_DITHER, 1'b0, 1'b1, 1'b1, CA2, CB2, EA2, EB_ONE), 3002);
        apply_stimulus(mk(MODE_DITHER, 1'b0, 1'b1, 1'b1, CA3, CB2, EA3, EB_TWO), 3003);
        apply_stimulus(idle(MODE_DITHER, 1'b0, 1'b0), 3004);
        apply_stimulus(idle(MODE_DITHER, 1'b0, 1'b0), 3005);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
